// File: rtl/mips_pkg.sv
// Encodings shared by the MIPS pipeline stages: ALU operations, destination-register
// selection, memory access widths and the operand-forwarding helper.
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_NOR  = 4'b0101,
        ALU_SLT  = 4'b0110,
        ALU_SLTU = 4'b0111,
        ALU_SLL  = 4'b1000,
        ALU_SRL  = 4'b1001,
        ALU_SRA  = 4'b1010,
        ALU_SLLV = 4'b1011,
        ALU_SRLV = 4'b1100,
        ALU_SRAV = 4'b1101,
        ALU_LUI  = 4'b1110,
        ALU_ZERO = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        DST_RT   = 2'b00,
        DST_RD   = 2'b01,
        DST_R31  = 2'b10,
        DST_ZERO = 2'b11
    } reg_dst_e;

    localparam logic [1:0] BYTE      = 2'b00;
    localparam logic [1:0] HALF_WORD = 2'b01;
    localparam logic [1:0] WORD      = 2'b10;

    localparam logic [4:0] REG_LINK = 5'd31;

    // EX/MEM is the younger producer, so it is checked before WB; r0 never forwards.
    function automatic logic [31:0] fwd_select(
        input logic        exmem_ok,
        input logic [4:0]  exmem_reg,
        input logic [31:0] exmem_data,
        input logic        wb_ok,
        input logic [4:0]  wb_reg,
        input logic [31:0] wb_data,
        input logic [4:0]  src_reg,
        input logic [31:0] raw_data
    );
        if (exmem_ok && exmem_reg != 5'd0 && exmem_reg == src_reg)
            return exmem_data;
        else if (wb_ok && wb_reg != 5'd0 && wb_reg == src_reg)
            return wb_data;
        else
            return raw_data;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit MIPS ALU. Immediate shifts use shamt_i, variable shifts use a_i[4:0].
module alu
    import mips_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [4:0]  shamt_i,
    input  alu_op_e     op_i,
    output logic [31:0] result_o
);

    logic slt_signed;
    logic slt_unsigned;

    assign slt_signed   = $signed(a_i) < $signed(b_i);
    assign slt_unsigned = a_i < b_i;

    always_comb begin
        result_o = 32'd0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_NOR:  result_o = ~(a_i | b_i);
            ALU_SLT:  result_o = {31'd0, slt_signed};
            ALU_SLTU: result_o = {31'd0, slt_unsigned};
            ALU_SLL:  result_o = b_i << shamt_i;
            ALU_SRL:  result_o = b_i >> shamt_i;
            ALU_SRA:  result_o = $unsigned($signed(b_i) >>> shamt_i);
            ALU_SLLV: result_o = b_i << a_i[4:0];
            ALU_SRLV: result_o = b_i >> a_i[4:0];
            ALU_SRAV: result_o = $unsigned($signed(b_i) >>> a_i[4:0]);
            ALU_LUI:  result_o = {b_i[15:0], 16'h0000};
            default:  result_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/etapa_ex.sv
// Execute stage: forwards rs/rt from EX/MEM and WB, runs the ALU, picks the destination
// register and loads the EX/MEM pipeline register.
module etapa_ex
    import mips_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    input  logic [31:0] i_imm,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_pc_plus_8,
    input  logic [3:0]  i_EX_alu_op,
    input  logic        i_EX_alu_src,
    input  logic [1:0]  i_EX_reg_dst,
    input  logic        i_EX_link,
    input  logic        i_WB_write,
    input  logic        i_WB_mem_to_reg,
    input  logic        i_MEM_read,
    input  logic        i_MEM_write,
    input  logic        i_MEM_unsigned,
    input  logic [1:0]  i_MEM_byte_half_word,
    input  logic        i_fwd_WB_write,
    input  logic [4:0]  i_fwd_WB_reg,
    input  logic [31:0] i_fwd_WB_data,
    output logic        o_WB_write,
    output logic        o_WB_mem_to_reg,
    output logic        o_MEM_read,
    output logic        o_MEM_write,
    output logic        o_MEM_unsigned,
    output logic [1:0]  o_MEM_byte_half_word,
    output logic [31:0] o_ALU_result,
    output logic [31:0] o_data_to_write_in_MEM,
    output logic [4:0]  o_write_reg
);

    logic        wb_write_q, wb_mem_to_reg_q, mem_read_q, mem_write_q, mem_unsigned_q;
    logic [1:0]  mem_bhw_q;
    logic [31:0] alu_result_q, store_data_q;
    logic [4:0]  write_reg_q;

    logic [31:0] rs_fwd, rt_fwd, operand_b, alu_out, result_d;
    logic [4:0]  write_reg_d;
    logic        exmem_fwd_ok;

    // The EX/MEM entry is only a forwarding source when both write-back flags are set.
    assign exmem_fwd_ok = wb_write_q && wb_mem_to_reg_q;

    assign rs_fwd = fwd_select(exmem_fwd_ok, write_reg_q, alu_result_q,
                               i_fwd_WB_write, i_fwd_WB_reg, i_fwd_WB_data, i_rs, i_rs_data);
    assign rt_fwd = fwd_select(exmem_fwd_ok, write_reg_q, alu_result_q,
                               i_fwd_WB_write, i_fwd_WB_reg, i_fwd_WB_data, i_rt, i_rt_data);

    assign operand_b = i_EX_alu_src ? i_imm : rt_fwd;

    alu u_alu (
        .a_i      (rs_fwd),
        .b_i      (operand_b),
        .shamt_i  (i_imm[10:6]),
        .op_i     (alu_op_e'(i_EX_alu_op)),
        .result_o (alu_out)
    );

    assign result_d = i_EX_link ? i_pc_plus_8 : alu_out;

    always_comb begin
        write_reg_d = 5'd0;
        case (reg_dst_e'(i_EX_reg_dst))
            DST_RT:  write_reg_d = i_rt;
            DST_RD:  write_reg_d = i_rd;
            DST_R31: write_reg_d = REG_LINK;
            default: write_reg_d = 5'd0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wb_write_q      <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_unsigned_q  <= 1'b0;
            mem_bhw_q       <= 2'b00;
            alu_result_q    <= 32'd0;
            store_data_q    <= 32'd0;
            write_reg_q     <= 5'd0;
        end else if (i_enable) begin
            wb_write_q      <= i_WB_write;
            wb_mem_to_reg_q <= i_WB_mem_to_reg;
            mem_read_q      <= i_MEM_read;
            mem_write_q     <= i_MEM_write;
            mem_unsigned_q  <= i_MEM_unsigned;
            mem_bhw_q       <= i_MEM_byte_half_word;
            alu_result_q    <= result_d;
            store_data_q    <= rt_fwd;
            write_reg_q     <= write_reg_d;
        end
    end

    assign o_WB_write             = wb_write_q;
    assign o_WB_mem_to_reg        = wb_mem_to_reg_q;
    assign o_MEM_read             = mem_read_q;
    assign o_MEM_write            = mem_write_q;
    assign o_MEM_unsigned         = mem_unsigned_q;
    assign o_MEM_byte_half_word   = mem_bhw_q;
    assign o_ALU_result           = alu_result_q;
    assign o_data_to_write_in_MEM = store_data_q;
    assign o_write_reg            = write_reg_q;

endmodule

// File: tb/tb_etapa_ex.sv
// Scoreboard bench for etapa_ex: the driver queues hand-computed EX/MEM contents,
// the monitor pops and compares them one cycle after each issue.
module tb_etapa_ex;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [31:0] rs_data, rt_data, imm, pc_plus_8;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  alu_op;
    logic        alu_src, link;
    logic [1:0]  reg_dst;
    logic        wb_write, mem_to_reg, mem_read, mem_write, mem_unsigned;
    logic [1:0]  bhw;
    logic        fwd_wb_write;
    logic [4:0]  fwd_wb_reg;
    logic [31:0] fwd_wb_data;

    logic        o_wb_write, o_mem_to_reg, o_mem_read, o_mem_write, o_mem_unsigned;
    logic [1:0]  o_bhw;
    logic [31:0] o_result, o_store;
    logic [4:0]  o_wr;

    etapa_ex dut (
        .i_clk                  (clk),
        .i_reset                (reset),
        .i_enable               (enable),
        .i_rs_data              (rs_data),
        .i_rt_data              (rt_data),
        .i_imm                  (imm),
        .i_rs                   (rs),
        .i_rt                   (rt),
        .i_rd                   (rd),
        .i_pc_plus_8            (pc_plus_8),
        .i_EX_alu_op            (alu_op),
        .i_EX_alu_src           (alu_src),
        .i_EX_reg_dst           (reg_dst),
        .i_EX_link              (link),
        .i_WB_write             (wb_write),
        .i_WB_mem_to_reg        (mem_to_reg),
        .i_MEM_read             (mem_read),
        .i_MEM_write            (mem_write),
        .i_MEM_unsigned         (mem_unsigned),
        .i_MEM_byte_half_word   (bhw),
        .i_fwd_WB_write         (fwd_wb_write),
        .i_fwd_WB_reg           (fwd_wb_reg),
        .i_fwd_WB_data          (fwd_wb_data),
        .o_WB_write             (o_wb_write),
        .o_WB_mem_to_reg        (o_mem_to_reg),
        .o_MEM_read             (o_mem_read),
        .o_MEM_write            (o_mem_write),
        .o_MEM_unsigned         (o_mem_unsigned),
        .o_MEM_byte_half_word   (o_bhw),
        .o_ALU_result           (o_result),
        .o_data_to_write_in_MEM (o_store),
        .o_write_reg            (o_wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] res;
        logic [31:0] st;
        logic [4:0]  wr;
        logic [6:0]  ctrl;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ctrl = {wb_write, mem_to_reg, mem_read, mem_write, mem_unsigned, bhw}
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_ALU   = 7'b1100000;
    localparam logic [6:0] C_STORE = 7'b0001010;

    task automatic check32(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s.%s: got 0x%08h, required 0x%08h", nm, fld, act, req);
        end
    endtask

    // Monitor: the EX/MEM register presents a new value every cycle; compare whenever one is due.
    always @(negedge clk) begin
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check32(nm, "result", o_result, e.res);
            check32(nm, "store",  o_store, e.st);
            check32(nm, "wr",     {27'd0, o_wr}, {27'd0, e.wr});
            check32(nm, "ctrl",   {25'd0, o_wb_write, o_mem_to_reg, o_mem_read, o_mem_write,
                                   o_mem_unsigned, o_bhw}, {25'd0, e.ctrl});
            $display("txn %-10s cyc=%0d result=0x%08h store=0x%08h wr=%0d", nm, cyc, o_result, o_store, o_wr);
        end
    end

    task automatic expect_out(input string nm, input logic [31:0] res, input logic [31:0] st,
                              input logic [4:0] wr, input logic [6:0] ctrl);
        exp_t e;
        e.due = cyc + 1;
        e.res = res;
        e.st = st;
        e.wr = wr;
        e.ctrl = ctrl;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [4:0] s, input logic [31:0] sd,
                             input logic [4:0] t, input logic [31:0] td, input logic [4:0] d,
                             input logic [1:0] dst, input logic src, input logic [31:0] im);
        alu_op = op; rs = s; rs_data = sd; rt = t; rt_data = td; rd = d;
        reg_dst = dst; alu_src = src; imm = im; link = 1'b0; pc_plus_8 = 32'h0;
        wb_write = 1'b1; mem_to_reg = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        mem_unsigned = 1'b0; bhw = 2'b00;
        fwd_wb_write = 1'b0; fwd_wb_reg = 5'd0; fwd_wb_data = 32'h0;
    endtask

    task automatic set_wb(input logic w, input logic [4:0] r, input logic [31:0] d);
        fwd_wb_write = w; fwd_wb_reg = r; fwd_wb_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b1;
        // Reset for two cycles with arbitrary inputs
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_instr(4'h0, 5'd1, 32'hAAAA_0000 + i, 5'd2, 32'h1234, 5'd9, 2'b01, 1'b0, 32'h55);
            set_wb(1'b1, 5'd1, 32'hFFFF);
            expect_out("reset", 32'h0, 32'h0, 5'd0, C_NONE);
        end
        @(negedge clk); reset = 1'b0;
        set_instr(4'h0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 2'b01, 1'b0, 32'h0);
        expect_out("add", 32'd12, 32'd7, 5'd3, C_ALU);

        @(negedge clk);   // SUB r4 = r3 - r1, r3 forwarded from EX/MEM
        set_instr(4'h1, 5'd3, 32'd0, 5'd1, 32'd5, 5'd4, 2'b01, 1'b0, 32'h0);
        expect_out("fwd_exmem", 32'd7, 32'd5, 5'd4, C_ALU);

        @(negedge clk);   // producer r3 = 12
        set_instr(4'h0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 2'b01, 1'b0, 32'h0);
        expect_out("prod_r3", 32'd12, 32'd7, 5'd3, C_ALU);

        @(negedge clk);   // r5 = r3 + r6, WB also offers r3 = 99
        set_instr(4'h0, 5'd3, 32'd0, 5'd6, 32'd1, 5'd5, 2'b01, 1'b0, 32'h0);
        set_wb(1'b1, 5'd3, 32'd99);
        expect_out("fwd_prio", 32'd13, 32'd1, 5'd5, C_ALU);

        @(negedge clk);   // producer targets r0
        set_instr(4'h0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd0, 2'b01, 1'b0, 32'h0);
        expect_out("prod_r0", 32'd12, 32'd7, 5'd0, C_ALU);

        @(negedge clk);   // reading r0: neither EX/MEM nor WB may forward
        set_instr(4'h0, 5'd0, 32'h11, 5'd7, 32'd2, 5'd8, 2'b01, 1'b0, 32'h0);
        set_wb(1'b1, 5'd0, 32'd99);
        expect_out("r0_nofwd", 32'h13, 32'd2, 5'd8, C_ALU);

        @(negedge clk);   // WB-only forward of rs
        set_instr(4'h0, 5'd9, 32'd0, 5'd10, 32'd3, 5'd11, 2'b01, 1'b0, 32'h0);
        set_wb(1'b1, 5'd9, 32'h20);
        expect_out("fwd_wb", 32'h23, 32'd3, 5'd11, C_ALU);

        @(negedge clk);   // SRA 0x80000000 by 4
        set_instr(4'hA, 5'd14, 32'd0, 5'd12, 32'h8000_0000, 5'd13, 2'b01, 1'b0, 32'h0000_0100);
        wb_write = 1'b0; mem_to_reg = 1'b0;
        expect_out("sra", 32'hF800_0000, 32'h8000_0000, 5'd13, C_NONE);

        @(negedge clk);   // SRLV by rs = 36 (uses low 5 bits = 4)
        set_instr(4'hC, 5'd14, 32'd36, 5'd12, 32'h8000_0000, 5'd13, 2'b01, 1'b0, 32'h0);
        wb_write = 1'b0; mem_to_reg = 1'b0;
        expect_out("srlv", 32'h0800_0000, 32'h8000_0000, 5'd13, C_NONE);

        @(negedge clk);
        set_instr(4'h6, 5'd14, 32'hFFFF_FFFF, 5'd12, 32'd1, 5'd13, 2'b01, 1'b0, 32'h0);
        wb_write = 1'b0; mem_to_reg = 1'b0;
        expect_out("slt", 32'd1, 32'd1, 5'd13, C_NONE);

        @(negedge clk);
        set_instr(4'h7, 5'd14, 32'hFFFF_FFFF, 5'd12, 32'd1, 5'd13, 2'b01, 1'b0, 32'h0);
        wb_write = 1'b0; mem_to_reg = 1'b0;
        expect_out("sltu", 32'd0, 32'd1, 5'd13, C_NONE);

        @(negedge clk);   // LUI 0x1234, destination rt
        set_instr(4'hE, 5'd0, 32'd0, 5'd19, 32'h5, 5'd0, 2'b00, 1'b1, 32'h0000_1234);
        wb_write = 1'b0; mem_to_reg = 1'b0;
        expect_out("lui", 32'h1234_0000, 32'h5, 5'd19, C_NONE);

        @(negedge clk);   // SW: address rs+8, data rt forwarded from WB
        set_instr(4'h0, 5'd15, 32'h100, 5'd16, 32'h0, 5'd0, 2'b00, 1'b1, 32'd8);
        wb_write = 1'b0; mem_to_reg = 1'b0; mem_write = 1'b1; bhw = 2'b10;
        set_wb(1'b1, 5'd16, 32'hDEAD);
        expect_out("sw", 32'h108, 32'hDEAD, 5'd16, C_STORE);

        @(negedge clk);   // JAL
        set_instr(4'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 2'b10, 1'b0, 32'h0);
        link = 1'b1; pc_plus_8 = 32'h40;
        expect_out("jal", 32'h40, 32'h0, 5'd31, C_ALU);

        // Hold for three cycles while inputs change
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            enable = 1'b0;
            set_instr(4'h0, 5'd1, 32'd100 + i, 5'd2, 32'd1, 5'd20 + 5'(i), 2'b01, 1'b0, 32'h0);
            mem_read = 1'b1;
            expect_out("hold", 32'h40, 32'h0, 5'd31, C_ALU);
        end

        @(negedge clk);   // resume: r31 still forwards from the held EX/MEM entry
        enable = 1'b1;
        set_instr(4'h0, 5'd31, 32'd0, 5'd17, 32'd2, 5'd18, 2'b01, 1'b0, 32'h0);
        expect_out("resume", 32'h42, 32'd2, 5'd18, C_ALU);

        @(negedge clk);   // mid-stream reset
        reset = 1'b1;
        set_instr(4'h0, 5'd1, 32'd9, 5'd2, 32'd9, 5'd18, 2'b01, 1'b0, 32'h0);
        expect_out("reset_mid", 32'h0, 32'h0, 5'd0, C_NONE);

        @(negedge clk);   // after reset EX/MEM offers nothing
        reset = 1'b0;
        set_instr(4'h0, 5'd1, 32'd3, 5'd2, 32'd4, 5'd1, 2'b01, 1'b0, 32'h0);
        expect_out("post_rst", 32'd7, 32'd4, 5'd1, C_ALU);

        @(negedge clk);   // consumer of r1 produced just after reset
        set_instr(4'h5, 5'd1, 32'd0, 5'd2, 32'h0000_FFF0, 5'd3, 2'b01, 1'b0, 32'h0);
        expect_out("nor_fwd", 32'hFFFF_0008, 32'h0000_FFF0, 5'd3, C_ALU);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
